// File: rtl/vending_pkg.sv
// Shared types and default parameters for the coin acceptor.
package vending_pkg;

    // Coin denomination as reported by the sensor head.
    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_FIVE = 2'b01,
        COIN_TEN  = 2'b10,
        COIN_BAD  = 2'b11
    } coin_t;

    // Coin qualification state machine.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_QUALIFY = 2'b01,
        ST_RELEASE = 2'b10
    } acc_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_FIFO_DEPTH      = 4;

    // Only five and ten rupee coins are creditable.
    function automatic logic coin_is_valid(input coin_t c);
        return (c == COIN_FIVE) || (c == COIN_TEN);
    endfunction

endpackage

// File: rtl/coin_fifo.sv
// Synchronous FIFO of qualified coins; supports push and pop in the same cycle.
module coin_fifo
    import vending_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  coin_t                    push_data,
    input  logic                     pop,
    output coin_t                    pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    coin_t           mem_q [DEPTH];
    coin_t           mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push_s;
    logic            do_pop_s;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == {CW{1'b0}});
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when a pop frees a slot this cycle.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= COIN_NONE;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes the sensor, debounces and qualifies each coin,
// buffers valid coins and emits one credit pulse per coin when downstream is ready.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          coin_sense,
    input  logic [1:0]                    coin_type,
    input  logic                          accept_en,
    output logic                          five_rup,
    output logic                          ten_rup,
    output logic                          reject,
    output logic [$clog2(FIFO_DEPTH):0]   coin_count
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_CYCLES);

    logic        sense_s1_q, sense_s2_q;
    logic [1:0]  type_s1_q, type_s2_q;
    acc_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    coin_t       held_q, held_d;
    logic        five_q, five_d;
    logic        ten_q, ten_d;
    logic        reject_q, reject_d;
    logic        qualify_s;
    logic        push_s;
    logic        pop_s;
    coin_t       type_sync_s;
    coin_t       head_s;
    logic        full_s;
    logic        empty_s;

    assign type_sync_s = coin_t'(type_s2_q);
    assign five_rup    = five_q;
    assign ten_rup     = ten_q;
    assign reject      = reject_q;

    // Two-flop synchronizer for the asynchronous sensor inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sense_s1_q <= 1'b0;
            sense_s2_q <= 1'b0;
            type_s1_q  <= 2'b00;
            type_s2_q  <= 2'b00;
        end else begin
            sense_s1_q <= coin_sense;
            sense_s2_q <= sense_s1_q;
            type_s1_q  <= coin_type;
            type_s2_q  <= type_s1_q;
        end
    end

    // Debounce FSM: qualify on a stable run, then wait for a stable release.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        qualify_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sense_s2_q) begin
                    state_d = ST_QUALIFY;
                    cnt_d   = 4'd1;
                    held_d  = type_sync_s;
                end else begin
                    cnt_d = 4'd0;
                end
            end
            ST_QUALIFY: begin
                if (!sense_s2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (type_sync_s != held_q) begin
                    cnt_d  = 4'd1;
                    held_d = type_sync_s;
                end else if ((cnt_q + 4'd1) == DEB) begin
                    qualify_s = 1'b1;
                    state_d   = ST_RELEASE;
                    cnt_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RELEASE: begin
                if (sense_s2_q) begin
                    cnt_d = 4'd0;
                end else if ((cnt_q + 4'd1) == DEB) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Pop/push decisions and next values of the registered output pulses.
    always_comb begin
        pop_s    = accept_en & ~empty_s;
        push_s   = qualify_s & coin_is_valid(held_q);
        reject_d = qualify_s & (~coin_is_valid(held_q) | (full_s & ~pop_s));
        five_d   = pop_s & (head_s == COIN_FIVE);
        ten_d    = pop_s & (head_s == COIN_TEN);
    end

    // FSM state and output pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            held_q   <= COIN_NONE;
            five_q   <= 1'b0;
            ten_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            held_q   <= held_d;
            five_q   <= five_d;
            ten_q    <= ten_d;
            reject_q <= reject_d;
        end
    end

    coin_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (held_q),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (coin_count)
    );

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor: directed scenarios plus random coins,
// checked by a scoreboard fed from a run-length behavioural model.
module tb_coin_acceptor;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          coin_sense;
    logic [1:0]    coin_type;
    logic          accept_en;
    logic          five_rup;
    logic          ten_rup;
    logic          reject;
    logic [CW-1:0] coin_count;

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_sense (coin_sense),
        .coin_type  (coin_type),
        .accept_en  (accept_en),
        .five_rup   (five_rup),
        .ten_rup    (ten_rup),
        .reject     (reject),
        .coin_count (coin_count)
    );

    typedef struct {
        int   cyc;
        logic f;
        logic t;
        logic r;
        int   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Model state: raw-sample delay line, run lengths, credit arming, coin queue.
    logic       d1_s, d2_s;
    logic [1:0] d1_t, d2_t;
    int         hi_run, lo_run;
    logic [1:0] run_type;
    bit         armed;
    int         mfifo[$];

    // Edge counter; after the k-th rising edge cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    // Predict what the outputs must show after edge ec, given the inputs now driven.
    task automatic model_step(input int ec);
        exp_t       e;
        logic       s;
        logic [1:0] t;
        bit         qual;
        bit         pop;
        bit         full;
        int         head;
        e.cyc = ec; e.f = 1'b0; e.t = 1'b0; e.r = 1'b0;
        if (rst) begin
            d1_s = 1'b0; d2_s = 1'b0; d1_t = 2'b00; d2_t = 2'b00;
            hi_run = 0; lo_run = 0; run_type = 2'b00; armed = 1'b1;
            mfifo.delete();
            e.cnt = 0;
            exp_q.push_back(e);
            return;
        end
        s = d2_s; t = d2_t;
        d2_s = d1_s; d2_t = d1_t;
        d1_s = coin_sense; d1_t = coin_type;
        if (s) begin
            if (hi_run > 0 && t == run_type) hi_run++;
            else begin hi_run = 1; run_type = t; end
            lo_run = 0;
        end else begin
            hi_run = 0;
            if (lo_run < 1000) lo_run++;
        end
        qual = armed && (hi_run == D);
        if (qual) armed = 1'b0;
        if (!armed && lo_run >= D) armed = 1'b1;
        pop  = accept_en && (mfifo.size() > 0);
        full = (mfifo.size() == DEPTH);
        if (pop) begin
            head = mfifo.pop_front();
            e.f = (head == 1);
            e.t = (head == 2);
        end
        if (qual) begin
            if (t == 2'b01 || t == 2'b10) begin
                if (!full || pop) mfifo.push_back(int'(t));
                else e.r = 1'b1;
            end else begin
                e.r = 1'b1;
            end
        end
        e.cnt = mfifo.size();
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic s, input logic [1:0] t, input logic a, input logic r);
        @(negedge clk);
        coin_sense = s; coin_type = t; accept_en = a; rst = r;
        model_step(cyc + 1);
    endtask

    task automatic insert(input logic [1:0] t, input int hold, input int low, input logic a);
        repeat (hold) tick(1'b1, t, a, 1'b0);
        repeat (low)  tick(1'b0, 2'b00, a, 1'b0);
    endtask

    // Monitor: compares every observed cycle against the scoreboard entry for it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("pulses{five,ten,reject}", int'({five_rup, ten_rup, reject}),
                      int'({e.f, e.t, e.r}));
                check("coin_count", int'(coin_count), e.cnt);
            end else if (five_rup === 1'b1 || ten_rup === 1'b1 || reject === 1'b1) begin
                check("unexpected_pulse", int'({five_rup, ten_rup, reject}), 0);
            end
        end
    end

    initial begin
        logic [1:0] rt;
        logic       ra;
        int         hold;
        coin_sense = 1'b0; coin_type = 2'b00; accept_en = 1'b0; rst = 1'b1;

        // Reset for two cycles, then idle.
        tick(1'b0, 2'b00, 1'b0, 1'b1);
        tick(1'b0, 2'b00, 1'b0, 1'b1);
        repeat (3) tick(1'b0, 2'b00, 1'b1, 1'b0);
        check("reset_outputs", int'({five_rup, ten_rup, reject}), 0);
        check("reset_count", int'(coin_count), 0);

        // Single five-rupee coin with downstream ready.
        insert(2'b01, 10, 10, 1'b1);

        // Bouncing sensor never reaches a stable run.
        tick(1'b1, 2'b01, 1'b1, 1'b0);
        tick(1'b1, 2'b01, 1'b1, 1'b0);
        tick(1'b0, 2'b01, 1'b1, 1'b0);
        tick(1'b1, 2'b01, 1'b1, 1'b0);
        tick(1'b1, 2'b01, 1'b1, 1'b0);
        tick(1'b1, 2'b01, 1'b1, 1'b0);
        tick(1'b0, 2'b01, 1'b1, 1'b0);
        repeat (8) tick(1'b0, 2'b00, 1'b1, 1'b0);

        // Invalid denomination is returned.
        insert(2'b11, 10, 10, 1'b1);
        check("invalid_count", int'(coin_count), 0);

        // Buffering with downstream stalled: fifth coin overflows.
        insert(2'b10, 6, 6, 1'b0);
        insert(2'b01, 6, 6, 1'b0);
        insert(2'b10, 6, 6, 1'b0);
        insert(2'b01, 6, 6, 1'b0);
        insert(2'b10, 6, 6, 1'b0);
        check("buffered_count", int'(coin_count), 4);
        repeat (8) tick(1'b0, 2'b00, 1'b1, 1'b0);
        check("drained_count", int'(coin_count), 0);

        // Reset with two coins buffered and a third mid-qualification.
        insert(2'b01, 6, 6, 1'b0);
        insert(2'b10, 6, 6, 1'b0);
        repeat (3) tick(1'b1, 2'b01, 1'b0, 1'b0);
        tick(1'b0, 2'b00, 1'b0, 1'b1);
        repeat (10) tick(1'b0, 2'b00, 1'b1, 1'b0);
        check("post_reset_count", int'(coin_count), 0);

        // Random coins with bounce, type glitches, stalls and rare resets.
        for (int n = 0; n < 200; n++) begin
            rt   = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 9);
            for (int h = 0; h < hold; h++) begin
                ra = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) rt = 2'($urandom_range(0, 3));
                tick(($urandom_range(0, 9) != 0), rt, ra, ($urandom_range(0, 299) == 0));
            end
            hold = $urandom_range(1, 9);
            for (int l = 0; l < hold; l++) begin
                ra = ($urandom_range(0, 3) != 0);
                tick(1'b0, 2'($urandom_range(0, 3)), ra, 1'b0);
            end
        end
        repeat (12) tick(1'b0, 2'b00, 1'b1, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive synchronized-high samples that qualify a coin (legal range 2..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of qualified coins buffered (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port coin_sense  input  1  raw, asynchronous coin-present sensor.
REQ-006 SHALL have port coin_type  input  2  raw denomination: 00 none, 01 five, 10 ten, 11 invalid.
REQ-007 SHALL have port accept_en  input  1  downstream vending machine ready to take a coin pulse.
REQ-008 SHALL have port five_rup  output  1  one-cycle pulse per credited five-rupee coin.
REQ-009 SHALL have port ten_rup  output  1  one-cycle pulse per credited ten-rupee coin.
REQ-010 SHALL have port reject  output  1  one-cycle pulse: coin returned (invalid type or FIFO full).
REQ-011 SHALL have port coin_count  output  $clog2(FIFO_DEPTH)+1  coins currently buffered.

Function
REQ-012 SHALL pass coin_sense and coin_type through a 2-flop synchronizer before any use.
REQ-013 SHALL implement FSM IDLE, QUALIFY, RELEASE; IDLE->QUALIFY when synced sense=1.
REQ-014 In QUALIFY, SHALL count consecutive edges with synced sense=1 and coin_type unchanged; sense=0 -> IDLE, type change -> count restarts at 1.
REQ-015 SHALL qualify the coin on the DEBOUNCE_CYCLES-th consecutive sample, act on it that edge, go to RELEASE.
REQ-016 In RELEASE, SHALL require DEBOUNCE_CYCLES consecutive synced sense=0 samples before IDLE; each coin credited exactly once.
REQ-017 Qualified type 01/10 SHALL push into FIFO; type 11 or 00 SHALL assert reject next cycle, no push.
REQ-018 Push with FIFO full and no same-cycle pop SHALL be dropped and assert reject next cycle.
REQ-019 Push with FIFO full and same-cycle pop SHALL succeed; coin_count unchanged.
REQ-020 When accept_en=1 and FIFO non-empty, SHALL pop one entry per edge and assert five_rup or ten_rup on the following cycle for exactly one cycle.
REQ-021 accept_en=0 SHALL hold FIFO contents; no pulses.
REQ-022 five_rup and ten_rup SHALL never be high together; reject independent of them.
REQ-023 Latency raw sense rise to pulse, FIFO empty, accept_en=1: DEBOUNCE_CYCLES+3 edges (7 at default).
REQ-024 coin_count SHALL update on the push/pop edge; order SHALL be FIFO.

Reset
REQ-025 rst=1 at an edge SHALL force FSM IDLE, debounce counter 0, synchronizers 0, FIFO empty.
REQ-026 Outputs after reset edge: five_rup=0, ten_rup=0, reject=0, coin_count=0.
REQ-027 Reset mid-QUALIFY or with buffered coins SHALL discard them; no pulse emitted for them.

Structure
REQ-028 Package vending_pkg SHALL hold coin_t enum (COIN_NONE, COIN_FIVE, COIN_TEN, COIN_BAD) and default parameter constants.
REQ-029 FIFO SHALL be sub-module coin_fifo (sync, full/empty/count, simultaneous push+pop).
REQ-030 Output pulses SHALL be registered; no combinational input-to-output path.

Verification
REQ-031 Reset: rst 2 cycles, then idle -> all outputs 0, coin_count=0.
REQ-032 Five coin: sense=1, type=01 held 10 cycles, accept_en=1 -> five_rup one cycle, 7 edges after assertion; one pulse only.
REQ-033 Bounce: sense toggles 1,1,0,1,1,1,0 per cycle -> no pulse, no reject.
REQ-034 Invalid: type=11 held 10 cycles -> reject one cycle, count stays 0.
REQ-035 Buffering: accept_en=0, insert ten,five,ten,five,ten -> count 4, 5th rejects; accept_en=1 -> ten,five,ten,five pulses on consecutive cycles, count 0.
REQ-036 Reset mid-operation: 2 coins buffered, rst 1 cycle, accept_en=1 -> no pulses, count=0.
